// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the sram_controller slice.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  // Halfword select appended below the word index to form the SRAM address
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Wide enough for WAIT_CYCLES in 0..7
  localparam int unsigned WAIT_CNT_W = 3;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable wait-state down-counter; `last` marks the final cycle of an SRAM phase.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on state entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign last = (r_cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// Word-to-halfword SRAM controller between the MEM stage and a 16-bit async SRAM.
// Optional address bound check: define SRAM_CTRL_BOUND_CHECK_EN (adds addr_err port).
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
`ifdef SRAM_CTRL_BOUND_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int unsigned           IDX_W        = ADDR_W - 1;
  localparam logic [WAIT_CNT_W-1:0] LP_WAIT      = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic                  LP_WAIT_ZERO = (WAIT_CYCLES == 0);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_load;
  logic              w_last;
  logic              w_oob;
  logic [31:0]       w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              w_unused_bits;

  // Byte offset from the window base; the word index wraps modulo capacity
  assign w_off = address - BASE_ADDR;
  assign w_idx = w_off[ADDR_W:2];

`ifdef SRAM_CTRL_BOUND_CHECK_EN
  logic r_err;

  // Below base wraps to a huge offset, so one test on the high bits covers both ends
  assign w_oob         = (address < BASE_ADDR) || (w_off[31:ADDR_W+1] != '0);
  assign w_unused_bits = ^w_off[1:0];
  assign addr_err      = (r_state == S_DONE) && r_err;

  // Remember whether the accepted request fell outside the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_oob;
    end
  end
`else
  assign w_oob         = 1'b0;
  assign w_unused_bits = ^{w_off[31:ADDR_W+1], w_off[1:0]};
`endif

  sram_wait_counter #(
    .CNT_W (WAIT_CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (LP_WAIT),
    .last     (w_last)
  );

  // Any state change is a state entry, which restarts the wait count
  assign w_load = (w_state_next != r_state);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; writes win when both requests arrive together
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_en || rd_en) begin
          w_accept = 1'b1;
          if (w_oob)      w_state_next = S_DONE;
          else if (wr_en) w_state_next = S_WR_LO;
          else            w_state_next = S_RD_LO;
        end
      end
      S_RD_LO: if (w_last) w_state_next = S_RD_HI;
      S_RD_HI: if (w_last) w_state_next = S_DONE;
      S_WR_LO: if (w_last) w_state_next = S_WR_HI;
      S_WR_HI: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the request on the accepting edge; later requests are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_idx   <= w_idx;
      r_wdata <= write_data;
    end
  end

  // Assemble the read word from the last cycle of each read phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_accept && w_oob) begin
      r_rdata <= '0;
    end else if (r_state == S_RD_LO && w_last) begin
      r_rdata[15:0] <= sram_dq_in;
    end else if (r_state == S_RD_HI && w_last) begin
      r_rdata[31:16] <= sram_dq_in;
    end
  end

  assign read_data = r_rdata;
  assign ready     = ((r_state == S_IDLE) && !rd_en && !wr_en) || (r_state == S_DONE);

  // SRAM pin drive; the write strobe drops one cycle early so data/address outlast it
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (r_state)
      S_RD_LO: begin
        sram_addr = {r_idx, HALF_LO};
        sram_oe_n = 1'b0;
      end
      S_RD_HI: begin
        sram_addr = {r_idx, HALF_HI};
        sram_oe_n = 1'b0;
      end
      S_WR_LO: begin
        sram_addr   = {r_idx, HALF_LO};
        sram_dq_out = r_wdata[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = ~(~w_last | LP_WAIT_ZERO);
      end
      S_WR_HI: begin
        sram_addr   = {r_idx, HALF_HI};
        sram_dq_out = r_wdata[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = ~(~w_last | LP_WAIT_ZERO);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM and word-level reference memory.
module tb_sram_controller;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int unsigned W    = 1;
  localparam int unsigned CAP  = 1 << (AW - 1);

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;
`ifdef SRAM_CTRL_BOUND_CHECK_EN
  logic          addr_err;
`endif

  sram_controller #(
    .BASE_ADDR   (32'(BASE)),
    .ADDR_W      (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
`ifdef SRAM_CTRL_BOUND_CHECK_EN
    ,
    .addr_err    (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM
  logic [15:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr] : 16'h5A5A;

  // Word-level reference memory, keyed by word index
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] written [$];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Per-access observations
  int unsigned   m_low, m_we, m_oe, m_dqoe;
  logic [AW-1:0] m_first_a, m_last_a;
  bit            m_seen, m_timeout;
  logic [31:0]   m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample_strobes();
    if (!sram_we_n) m_we++;
    if (!sram_oe_n) m_oe++;
    if (sram_dq_oe) m_dqoe++;
    if (!sram_we_n || !sram_oe_n) begin
      if (!m_seen) m_first_a = sram_addr;
      m_last_a = sram_addr;
      m_seen   = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // Present a request now and follow it until ready returns; requests stay asserted afterwards
  task automatic access(input bit do_wr, input bit do_rd, input logic [31:0] a, input logic [31:0] d);
    m_low = 0; m_we = 0; m_oe = 0; m_dqoe = 0;
    m_seen = 1'b0; m_timeout = 1'b1;
    m_first_a = '0; m_last_a = '0; m_rdata = '0;
    wr_en = do_wr; rd_en = do_rd; address = a; write_data = d;
    #1;
    sample_strobes();
    if (!ready) m_low++;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      sample_strobes();
      if (ready) begin
        m_timeout = 1'b0;
        m_rdata   = read_data;
        break;
      end
      m_low++;
    end
  endtask

  task automatic run_op(input bit do_wr, input bit do_rd, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int unsigned idx;
    logic [31:0] exp_rd;
    idx = ((a - BASE) >> 2) % CAP;
    access(do_wr, do_rd, a, d);
    check({tag, "_timeout"},   32'(m_timeout), 32'd0);
    check({tag, "_ready_low"}, m_low, 32'(1 + 2 * (W + 1)));
    check({tag, "_addr_lo"},   32'(m_first_a), 32'(idx * 2));
    check({tag, "_addr_hi"},   32'(m_last_a),  32'(idx * 2 + 1));
`ifdef SRAM_CTRL_BOUND_CHECK_EN
    check({tag, "_addr_err"},  32'(addr_err), 32'd0);
`endif
    if (do_wr) begin
      ref_mem[idx] = d;
      check({tag, "_we_cycles"}, m_we, 32'(2 * ((W == 0) ? 1 : W)));
      check({tag, "_oe_cycles"}, m_oe, 32'd0);
      check({tag, "_dqoe"},      m_dqoe, 32'(2 * (W + 1)));
      check({tag, "_mem_lo"},    32'(sram_mem[idx * 2]),     32'(d[15:0]));
      check({tag, "_mem_hi"},    32'(sram_mem[idx * 2 + 1]), 32'(d[31:16]));
    end else begin
      exp_rd = ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
      check({tag, "_we_cycles"}, m_we, 32'd0);
      check({tag, "_oe_cycles"}, m_oe, 32'(2 * (W + 1)));
      check({tag, "_dqoe"},      m_dqoe, 32'd0);
      check({tag, "_rdata"},     m_rdata, exp_rd);
    end
  endtask

`ifdef SRAM_CTRL_BOUND_CHECK_EN
  task automatic run_err(input bit do_wr, input logic [31:0] a, input string tag);
    wr_en = do_wr; rd_en = !do_wr; address = a; write_data = 32'hCAFE_F00D;
    #1;
    check({tag, "_idle_ready"}, 32'(ready), 32'd0);
    check({tag, "_idle_oe_n"},  32'(sram_oe_n), 32'd1);
    check({tag, "_idle_we_n"},  32'(sram_we_n), 32'd1);
    @(negedge clk);
    #1;
    check({tag, "_done_ready"}, 32'(ready), 32'd1);
    check({tag, "_addr_err"},   32'(addr_err), 32'd1);
    check({tag, "_rdata_zero"}, read_data, 32'd0);
    check({tag, "_done_oe_n"},  32'(sram_oe_n), 32'd1);
    check({tag, "_done_we_n"},  32'(sram_we_n), 32'd1);
    idle_cycle();
    check({tag, "_err_clear"},  32'(addr_err), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bit          b2b;

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    @(negedge clk);
    #1;
    check("rst_read_data", read_data, 32'd0);
    check("rst_ready",     32'(ready), 32'd1);
    check("rst_we_n",      32'(sram_we_n), 32'd1);
    check("rst_oe_n",      32'(sram_oe_n), 32'd1);
    check("rst_dq_oe",     32'(sram_dq_oe), 32'd0);
    check("rst_addr",      32'(sram_addr), 32'd0);
    check("rst_dq_out",    32'(sram_dq_out), 32'd0);
`ifdef SRAM_CTRL_BOUND_CHECK_EN
    check("rst_addr_err",  32'(addr_err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Directed: first write and read back
    run_op(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, "wr1024");
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, "rd1024");
    idle_cycle();

    // Back-to-back write then read of the next word
    run_op(1'b1, 1'b0, 32'd1028, 32'h1234_5678, "wr1028");
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, "b2b_rd1028");
    idle_cycle();

    // Simultaneous requests: the write must win
    run_op(1'b1, 1'b1, 32'd1032, 32'hA5C3_0F96, "both");
    idle_cycle();

    // Reset asserted during the RD_HI phase
    rd_en = 1'b1; address = 32'd1024;
    #1;
    repeat (W + 2) @(negedge clk);
    #1;
    check("midrst_in_rdhi_oe", 32'(sram_oe_n), 32'd0);
    check("midrst_in_rdhi_addr", 32'(sram_addr), 32'd1);
    rst = 1'b1; rd_en = 1'b0;
    #1;
    check("midrst_ready",  32'(ready), 32'd1);
    check("midrst_oe_n",   32'(sram_oe_n), 32'd1);
    check("midrst_rdata",  read_data, 32'd0);
    @(negedge clk);
    #1;
    check("midrst_hold_ready", 32'(ready), 32'd1);
    check("midrst_hold_addr",  32'(sram_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, "post_rst_rd");
    idle_cycle();

`ifdef SRAM_CTRL_BOUND_CHECK_EN
    run_err(1'b0, 32'd1020, "oob_below");
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, "rd_after_err");
    idle_cycle();
    run_err(1'b1, BASE + 4 * CAP, "oob_top");
    run_op(1'b1, 1'b0, BASE + 4 * CAP - 4, 32'h0BAD_CAFE, "wr_top_word");
    idle_cycle();
    run_op(1'b0, 1'b1, BASE + 4 * CAP - 4, 32'h0, "rd_top_word");
    idle_cycle();
`else
    // Without the bound check the index wraps modulo capacity
    run_op(1'b1, 1'b0, BASE + 4 * CAP + 8, 32'h7E57_0001, "wr_wrap");
    idle_cycle();
    run_op(1'b0, 1'b1, 32'd1032, 32'h0, "rd_wrap");
    idle_cycle();
`endif

    // Randomized mix of reads and writes, some back-to-back
    for (int n = 0; n < 24; n++) begin
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) idle_cycle();
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = BASE + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
        d = $urandom;
        run_op(1'b1, ($urandom_range(0, 3) == 0), a, d, "rand_wr");
        written.push_back(a);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        a = {a[31:2], 2'($urandom_range(0, 3))};
        run_op(1'b0, 1'b1, a, 32'h0, "rand_rd");
      end
    end
    idle_cycle();
    check("final_idle_ready", 32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sits between the MEM stage of the ARM pipeline and an external 16-bit asynchronous SRAM. It translates one 32-bit word access into two sequenced halfword SRAM cycles with programmable wait states. It holds `ready` low so the hazard/freeze logic stalls the pipeline until the access completes.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `ADDR_W`, 18: SRAM halfword address width. Capacity is 2^(ADDR_W-1) words.
- `WAIT_CYCLES`, 1: extra cycles held per halfword access. Range 0..7.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_en` in 1: word read request from the MEM stage.
- `wr_en` in 1: word write request from the MEM stage.
- `address` in 32: byte address. Bits [1:0] are ignored.
- `write_data` in 32: word to write.
- `read_data` out 32: word read. Valid while `ready`=1 in DONE.
- `ready` out 1: high when no access is pending or the access is complete. Pipeline freezes while low.
- `sram_addr` out ADDR_W: halfword address.
- `sram_dq_out` out 16: write data to the SRAM.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_dq_oe` out 1: drive enable for the data pins (top-level tristate).
- `sram_we_n` out 1: active-low write strobe.
- `sram_oe_n` out 1: active-low output enable.
- `addr_err` out 1: out-of-range flag. Only present with the bound-check macro.

## Operation
- Word index = (`address` − `BASE_ADDR`) >> 2, truncated to ADDR_W−1 bits.
- Low half address = {idx, 0}. High half address = {idx, 1}.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - `wr_en` → WR_LO.
  - else `rd_en` → RD_LO.
  - `wr_en` has priority when both requests are asserted.
  - `address` and `write_data` are latched on the accepting edge.
- Each LO/HI state lasts WAIT_CYCLES+1 cycles, counted by the wait counter. The counter reloads on every state entry.
- RD_LO/RD_HI:
  - `sram_oe_n`=0 and `sram_dq_oe`=0.
  - `sram_dq_in` is captured on the last cycle into `read_data`[15:0] or [31:16] respectively.
- WR_LO/WR_HI:
  - `sram_dq_oe`=1.
  - `sram_dq_out` = latched data [15:0] or [31:16].
  - `sram_we_n`=0 on every cycle except the last, so data and address are held one cycle past the strobe.
  - With WAIT_CYCLES=0, `sram_we_n`=0 for the single cycle.
- RD_HI and WR_HI → DONE.
- DONE lasts one cycle with `ready`=1, then → IDLE unconditionally. The pipeline advances on that edge, so the request seen in the following IDLE is the next instruction.
- `ready` = (IDLE and no request) or DONE. It is combinational from the state and request inputs.
- `read_data` holds its last value outside DONE.
- Reset, including mid-access:
  - State returns to IDLE. The access is abandoned and no partial retry is made.
  - Reset values: `read_data`=0, `ready`=1, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0, `addr_err`=0.

## Timing
- Read latency, request to DONE: 1 + 2·(WAIT_CYCLES+1) cycles with `ready`=0.
  - WAIT_CYCLES=1: `ready` is low 5 cycles, then high 1 cycle.
- Write latency is identical.
- Back-to-back requests: one IDLE cycle is always inserted after DONE (ready=0 if the next request is present).
- Requests in non-IDLE states are ignored; the inputs are already latched.

## Configuration
- `SRAM_CTRL_BOUND_CHECK_EN` defined:
  - An address below `BASE_ADDR` or at or beyond `BASE_ADDR` + 4·2^(ADDR_W-1) goes IDLE→DONE directly.
  - `addr_err`=1 during that DONE cycle. No SRAM strobe, `read_data`=0.
- Undefined:
  - No check. The address wraps modulo capacity.
  - The `addr_err` port is absent.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum type.
  - `HALF_LO`/`HALF_HI` constants.
  - default `BASE_ADDR`.
  - wait-counter width (3).
- One sub-module, `sram_wait_counter`: loadable down-counter with a `last` output. It is reloaded on state entry.

## Test plan
- Reset, then write 0xDEADBEEF to 1024 with WAIT_CYCLES=1 → halfword 0 gets 0xBEEF and halfword 1 gets 0xDEAD; `ready` is low 5 cycles.
- Read 1024 with the SRAM model returning stored data → `read_data`=0xDEADBEEF in DONE with `ready`=1.
- Write 0x12345678 to 1028, then read it back-to-back → `sram_addr` 2/3; read returns 0x12345678; one IDLE gap between accesses.
- `rd_en`=`wr_en`=1 → write performed; no `sram_oe_n` assertion.
- Assert `rst` during RD_HI → next cycle IDLE, `ready`=1, `sram_oe_n`=1, `read_data`=0.
- With `SRAM_CTRL_BOUND_CHECK_EN`, read address 1020 → DONE after 1 cycle, `addr_err`=1, no SRAM strobes.
